// File: rtl/ysyx_24070016_mem_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states and requester IDs.
package ysyx_24070016_mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_RESP,
      ST_DRAIN
   } state_e;

   localparam logic MID_IFU = 1'b0;
   localparam logic MID_LSU = 1'b1;

endpackage

// File: rtl/ysyx_24070016_mem_arbiter_if.sv
// Requester and memory-side signal bundle; slave is the arbiter's view, master the environment's.
interface ysyx_24070016_mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            ifu_req_valid;
   logic            ifu_req_ready;
   logic [AW-1:0]   ifu_addr;
   logic            ifu_rsp_valid;
   logic [DW-1:0]   ifu_rsp_rdata;
   logic            ifu_rsp_err;

   logic            lsu_req_valid;
   logic            lsu_req_ready;
   logic [AW-1:0]   lsu_addr;
   logic            lsu_wen;
   logic [DW-1:0]   lsu_wdata;
   logic [DW/8-1:0] lsu_wmask;
   logic            lsu_rsp_valid;
   logic [DW-1:0]   lsu_rsp_rdata;
   logic            lsu_rsp_err;

   logic            mem_req_valid;
   logic            mem_req_ready;
   logic [AW-1:0]   mem_addr;
   logic            mem_wen;
   logic [DW-1:0]   mem_wdata;
   logic [DW/8-1:0] mem_wmask;
   logic            mem_rsp_valid;
   logic [DW-1:0]   mem_rsp_rdata;
   logic            mem_rsp_err;

   modport slave (
      input  ifu_req_valid, ifu_addr,
      input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
      output ifu_req_ready, ifu_rsp_valid, ifu_rsp_rdata, ifu_rsp_err,
      output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
      output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
   );

   modport master (
      output ifu_req_valid, ifu_addr,
      output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
      output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
      input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_rdata, ifu_rsp_err,
      input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
      input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
   );

endinterface

// File: rtl/ysyx_24070016_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational: a tie goes to the requester not granted last.
module ysyx_24070016_rr_arb2
   import ysyx_24070016_mem_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       enable,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (enable) begin
         if (req == 2'b11) begin
            grant = (last_grant == MID_LSU) ? 2'b01 : 2'b10;
         end else begin
            grant = req;
         end
      end
   end

endmodule

// File: rtl/ysyx_24070016_mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction in flight; accept->response is 3 cycles minimum.
// Requests are only accepted in IDLE; a stalled memory response becomes an error after TIMEOUT wait cycles.
module ysyx_24070016_mem_arbiter
   import ysyx_24070016_mem_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255,
   parameter int TW      = 8
) (
   input  logic clk,
   input  logic rst,
   ysyx_24070016_mem_arbiter_if.slave bus
);

   localparam int MW = DW / 8;

   state_e        state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic          owner_q, owner_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          wen_q, wen_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [MW-1:0] wmask_q, wmask_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          err_q, err_d;
   logic          drain_q, drain_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [1:0]    grant;
   logic          timeout_hit;

   // Gating with rst keeps req_ready low while reset is held, even with requests pending.
   ysyx_24070016_rr_arb2 u_arb (
      .req        ({bus.lsu_req_valid, bus.ifu_req_valid}),
      .last_grant (last_grant_q),
      .enable     (rst && (state_q == ST_IDLE)),
      .grant      (grant)
   );

   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TW'(TIMEOUT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= MID_LSU;
         owner_q      <= MID_IFU;
         addr_q       <= '0;
         wen_q        <= 1'b0;
         wdata_q      <= '0;
         wmask_q      <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         drain_q      <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         addr_q       <= addr_d;
         wen_q        <= wen_d;
         wdata_q      <= wdata_d;
         wmask_q      <= wmask_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
         drain_q      <= drain_d;
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      addr_d       = addr_q;
      wen_d        = wen_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      drain_d      = drain_q;
      cnt_d        = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (|grant) begin
               owner_d      = grant[MID_LSU];
               last_grant_d = grant[MID_LSU];
               state_d      = ST_REQ;
               if (grant[MID_LSU]) begin
                  addr_d  = bus.lsu_addr;
                  wen_d   = bus.lsu_wen;
                  wdata_d = bus.lsu_wdata;
                  wmask_d = bus.lsu_wmask;
               end else begin
                  addr_d  = bus.ifu_addr;
                  wen_d   = 1'b0;
                  wdata_d = '0;
                  wmask_d = '1;
               end
            end
         end
         ST_REQ: begin
            if (bus.mem_req_ready) begin
               cnt_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + TW'(1);
            // A response landing on the timeout cycle still counts as a real response.
            if (bus.mem_rsp_valid) begin
               rdata_d = bus.mem_rsp_rdata;
               err_d   = bus.mem_rsp_err;
               state_d = ST_RESP;
            end else if (timeout_hit) begin
               rdata_d = '0;
               err_d   = 1'b1;
               drain_d = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = drain_q ? ST_DRAIN : ST_IDLE;
         end
         ST_DRAIN: begin
            if (bus.mem_rsp_valid) begin
               drain_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.ifu_req_ready = grant[MID_IFU];
      bus.lsu_req_ready = grant[MID_LSU];
      bus.ifu_rsp_valid = (state_q == ST_RESP) && (owner_q == MID_IFU);
      bus.lsu_rsp_valid = (state_q == ST_RESP) && (owner_q == MID_LSU);
      bus.ifu_rsp_rdata = rdata_q;
      bus.lsu_rsp_rdata = rdata_q;
      bus.ifu_rsp_err   = err_q;
      bus.lsu_rsp_err   = err_q;
      bus.mem_req_valid = (state_q == ST_REQ);
      bus.mem_addr      = addr_q;
      bus.mem_wen       = wen_q;
      bus.mem_wdata     = wdata_q;
      bus.mem_wmask     = wmask_q;
   end

endmodule

// File: tb/tb_ysyx_24070016_mem_arbiter.sv
// Randomized bench for the memory arbiter against a transaction-level timing model.
module tb_ysyx_24070016_mem_arbiter;
   import ysyx_24070016_mem_pkg::*;

   localparam int TO    = 4;
   localparam int NEVER = 32'h7fff_ffff;

   logic clk;
   logic rst;

   ysyx_24070016_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

   ysyx_24070016_mem_arbiter #(
      .AW(32), .DW(32), .TIMEOUT(TO), .TW(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   int p_ifu, p_lsu, p_rdy, p_stall, p_err;

   // Model: a transaction is accepted when the port is free, requested from the next
   // cycle until memory takes it, answered the cycle after memory replies (or after
   // TIMEOUT+1 wait cycles with an error), and the port frees the cycle after that.
   logic        last_mid;
   int          free_at, req_from, hs_cycle, drv_cycle, exp_cycle;
   logic        req_out, ifu_taken, lsu_taken;
   logic        t_owner, t_wen;
   logic [31:0] t_addr, t_wdata;
   logic [3:0]  t_wmask;
   logic [31:0] drv_data, exp_data;
   logic        drv_err, exp_err, exp_dchk;
   logic        grants[$];

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
   endtask

   task automatic model_reset();
      last_mid  = MID_LSU;
      free_at   = 0;
      req_out   = 1'b0;
      req_from  = NEVER;
      hs_cycle  = 0;
      drv_cycle = -1;
      exp_cycle = -1;
      ifu_taken = 1'b0;
      lsu_taken = 1'b0;
   endtask

   task automatic set_policy(input int pi, input int pl, input int pr, input int ps, input int pe);
      p_ifu = pi; p_lsu = pl; p_rdy = pr; p_stall = ps; p_err = pe;
   endtask

   task automatic raise_ifu();
      bus.ifu_req_valid = 1'b1;
      bus.ifu_addr      = $urandom;
   endtask

   task automatic raise_lsu();
      bus.lsu_req_valid = 1'b1;
      bus.lsu_addr      = $urandom;
      bus.lsu_wen       = 1'($urandom);
      bus.lsu_wdata     = $urandom;
      bus.lsu_wmask     = 4'($urandom);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
      check({tag, "_rsp"}, {bus.ifu_rsp_valid, bus.ifu_rsp_err, bus.lsu_rsp_valid, bus.lsu_rsp_err}, 0);
      check({tag, "_rdata"}, {bus.ifu_rsp_rdata, bus.lsu_rsp_rdata}, 0);
      check({tag, "_mem_ctl"}, {bus.mem_req_valid, bus.mem_wen, bus.mem_wmask}, 0);
      check({tag, "_mem_data"}, {bus.mem_addr, bus.mem_wdata}, 0);
   endtask

   task automatic run_cycles(input int n);
      logic e_ifu, e_lsu, e_mreq, winner;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            rst     = 1'b1;
            free_at = cyc;
         end
         if (ifu_taken) begin bus.ifu_req_valid = 1'b0; ifu_taken = 1'b0; end
         if (lsu_taken) begin bus.lsu_req_valid = 1'b0; lsu_taken = 1'b0; end
         if (!bus.ifu_req_valid && $urandom_range(99) < p_ifu) raise_ifu();
         if (!bus.lsu_req_valid && $urandom_range(99) < p_lsu) raise_lsu();
         bus.mem_req_ready = ($urandom_range(99) < p_rdy);
         bus.mem_rsp_valid = (cyc == drv_cycle);
         bus.mem_rsp_rdata = (cyc == drv_cycle) ? drv_data : $urandom;
         bus.mem_rsp_err   = (cyc == drv_cycle) ? drv_err : 1'($urandom);
         #1;
         e_ifu = (cyc >= free_at) && bus.ifu_req_valid && (!bus.lsu_req_valid || last_mid == MID_LSU);
         e_lsu = (cyc >= free_at) && bus.lsu_req_valid && (!bus.ifu_req_valid || last_mid == MID_IFU);
         check("ifu_req_ready", bus.ifu_req_ready, e_ifu);
         check("lsu_req_ready", bus.lsu_req_ready, e_lsu);
         if (bus.ifu_req_ready || bus.lsu_req_ready) grants.push_back(bus.lsu_req_ready);
         e_mreq = req_out && (cyc >= req_from);
         check("mem_req_valid", bus.mem_req_valid, e_mreq);
         if (e_mreq) begin
            check("mem_addr", bus.mem_addr, t_addr);
            check("mem_wen", bus.mem_wen, t_wen);
            check("mem_wdata", bus.mem_wdata, t_wdata);
            check("mem_wmask", bus.mem_wmask, t_wmask);
         end
         check("ifu_rsp_valid", bus.ifu_rsp_valid, (cyc == exp_cycle) && (t_owner == MID_IFU));
         check("lsu_rsp_valid", bus.lsu_rsp_valid, (cyc == exp_cycle) && (t_owner == MID_LSU));
         if (cyc == exp_cycle) begin
            if (t_owner == MID_IFU) begin
               if (exp_dchk) check("ifu_rsp_rdata", bus.ifu_rsp_rdata, exp_data);
               check("ifu_rsp_err", bus.ifu_rsp_err, exp_err);
            end else begin
               if (exp_dchk) check("lsu_rsp_rdata", bus.lsu_rsp_rdata, exp_data);
               check("lsu_rsp_err", bus.lsu_rsp_err, exp_err);
            end
         end
         if (e_mreq && bus.mem_req_ready) begin
            req_out  = 1'b0;
            hs_cycle = cyc;
            drv_data = $urandom;
            if ($urandom_range(99) < p_stall) begin
               exp_cycle = cyc + 2 + TO;
               drv_cycle = exp_cycle + int'($urandom_range(4, 2));
               drv_err   = 1'($urandom);
               exp_data  = 32'h0;
               exp_err   = 1'b1;
               exp_dchk  = 1'b1;
               free_at   = drv_cycle + 1;
            end else begin
               drv_cycle = cyc + 1 + int'($urandom_range(TO, 0));
               drv_err   = ($urandom_range(99) < p_err);
               exp_cycle = drv_cycle + 1;
               exp_data  = drv_data;
               exp_err   = drv_err;
               exp_dchk  = !t_wen;
               free_at   = exp_cycle + 1;
            end
         end
         if (e_ifu || e_lsu) begin
            winner   = e_lsu;
            last_mid = winner;
            t_owner  = winner;
            if (winner == MID_LSU) begin
               t_addr = bus.lsu_addr; t_wen = bus.lsu_wen;
               t_wdata = bus.lsu_wdata; t_wmask = bus.lsu_wmask;
               lsu_taken = 1'b1;
            end else begin
               t_addr = bus.ifu_addr; t_wen = 1'b0;
               t_wdata = 32'h0; t_wmask = 4'hf;
               ifu_taken = 1'b1;
            end
            req_out  = 1'b1;
            req_from = cyc + 1;
            free_at  = NEVER;
         end
      end
   endtask

   initial begin
      logic found;
      rst = 1'b1;
      bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h1234_5678;
      bus.lsu_req_valid = 1'b1; bus.lsu_addr = 32'h8765_4321;
      bus.lsu_wen = 1'b1; bus.lsu_wdata = 32'hffff_ffff; bus.lsu_wmask = 4'hf;
      bus.mem_req_ready = 1'b1; bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = 32'h0; bus.mem_rsp_err = 1'b0;
      model_reset();
      set_policy(0, 0, 100, 0, 0);
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      #1 check_reset_outputs("por");

      // IFU alone: accept in cycle 0, memory replies in cycle 2, response in cycle 3.
      @(negedge clk);
      rst = 1'b1;
      bus.lsu_req_valid = 1'b0;
      bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0000;
      bus.mem_req_ready = 1'b1;
      #1 check("t1_c0_ifu_ready", bus.ifu_req_ready, 1);
      check("t1_c0_lsu_ready", bus.lsu_req_ready, 0);
      @(negedge clk);
      bus.ifu_req_valid = 1'b0;
      #1 check("t1_c1_mem_req_valid", bus.mem_req_valid, 1);
      check("t1_c1_mem_addr", bus.mem_addr, 32'h8000_0000);
      check("t1_c1_mem_wen_wmask", {bus.mem_wen, bus.mem_wmask}, 5'h0f);
      @(negedge clk);
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'h0000_0413; bus.mem_rsp_err = 1'b0;
      #1 check("t1_c2_mem_req_valid", bus.mem_req_valid, 0);
      check("t1_c2_ifu_rsp_valid", bus.ifu_rsp_valid, 0);
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = 32'hffff_ffff; bus.mem_rsp_err = 1'b1;
      #1 check("t1_c3_ifu_rsp_valid", bus.ifu_rsp_valid, 1);
      check("t1_c3_ifu_rsp_rdata", bus.ifu_rsp_rdata, 32'h0000_0413);
      check("t1_c3_ifu_rsp_err", bus.ifu_rsp_err, 0);
      check("t1_c3_lsu_rsp_valid", bus.lsu_rsp_valid, 0);
      @(negedge clk);
      #1 check("t1_c4_rsp_valids", {bus.ifu_rsp_valid, bus.lsu_rsp_valid}, 0);
      last_mid = MID_IFU;

      // Both requesters held valid: grants must alternate.
      set_policy(100, 100, 100, 0, 0);
      grants.delete();
      run_cycles(40);
      check("contention_grants_ge4", grants.size() >= 4, 1);
      for (int i = 1; i < grants.size(); i++) check("contention_alternate", grants[i], !grants[i-1]);

      set_policy(30, 70, 30, 0, 20);   // slow mem_req_ready, writes, errors
      run_cycles(300);
      set_policy(60, 60, 70, 40, 10);  // frequent timeouts with late responses
      run_cycles(400);

      // Reset while waiting on memory.
      set_policy(100, 100, 100, 60, 0);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         run_cycles(1);
         found = (hs_cycle < cyc) && (cyc < exp_cycle);
      end
      check("midop_found_wait", found, 1);
      #1 rst = 1'b0;
      #1 check_reset_outputs("midop");
      model_reset();
      bus.mem_rsp_valid = 1'b0;
      raise_ifu();
      raise_lsu();
      run_cycles(1);
      check("midop_tie_ifu_ready", bus.ifu_req_ready, 1);
      check("midop_tie_lsu_ready", bus.lsu_req_ready, 0);
      run_cycles(50);

      set_policy(50, 50, 60, 15, 15);
      run_cycles(800);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ysyx_24070016_mem_arbiter.md
Name: ysyx_24070016_mem_arbiter

Overview:
- Shares one memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU), for the multi-cycle core.
- Sits between the core units and the memory wrapper.
- Arbitrates round-robin, with at most one transaction outstanding.
- Holds each accepted request, forwards the response to its owner, and converts a stalled response into an error after a timeout.

Parameters:
- AW, 32: address width.
- DW, 32: data width (must be a multiple of 8).
- TIMEOUT, 255: maximum cycles in WAIT before an error response is returned. 0 disables the timeout.
- TW, 8: timeout counter width. Must satisfy 2^TW > TIMEOUT.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  AW  IFU read address
ifu_rsp_valid  out  1  one-cycle response pulse to IFU
ifu_rsp_rdata  out  DW  IFU read data
ifu_rsp_err  out  1  IFU error/timeout
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  AW  LSU address
lsu_wen  in  1  1 = write, 0 = read
lsu_wdata  in  DW  write data
lsu_wmask  in  DW/8  byte enables
lsu_rsp_valid  out  1  one-cycle response pulse to LSU
lsu_rsp_rdata  out  DW  LSU read data
lsu_rsp_err  out  1  LSU error/timeout
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  AW  held address
mem_wen  out  1  held write flag
mem_wdata  out  DW  held write data
mem_wmask  out  DW/8  held mask
mem_rsp_valid  in  1  memory response
mem_rsp_rdata  in  DW  memory read data
mem_rsp_err  in  1  memory error

Behaviour:
- State machine states:
  - IDLE, REQ, WAIT, RESP, DRAIN.
  - Reset value is IDLE.
- Reset (rst low) values:
  - All outputs 0.
  - Holding registers 0.
  - last_grant = LSU, so IFU wins the first tie.
  - Timeout counter 0.
- Reset mid-transaction abandons the in-flight access; the memory model must be reset alongside.
- IDLE:
  - Winner = the only valid requester. If both are valid, the one not equal to last_grant wins.
  - The winner's req_ready is asserted combinationally in the same cycle; the loser's req_ready is 0.
  - On acceptance: latch addr/wen/wdata/wmask (IFU: wen=0, wmask=all ones, wdata=0) and owner; update last_grant to the winner; go to REQ.
  - With no valid requester, stay in IDLE. No req_ready is asserted outside IDLE.
- REQ:
  - mem_req_valid=1, with the held fields stable.
  - When mem_req_ready=1: go to WAIT and clear the counter.
  - mem_req_valid never drops before the handshake.
- WAIT:
  - Counter increments every cycle.
  - On mem_rsp_valid: capture rdata and err, go to RESP. A response arriving in the same cycle as counter==TIMEOUT takes priority over the timeout.
  - Else if TIMEOUT!=0 and counter==TIMEOUT: capture rdata=0, err=1, go to DRAIN_PENDING. This is encoded as RESP with a drain flag set.
- RESP:
  - The owner's rsp_valid=1 for exactly one cycle, with the registered rdata/err.
  - The other master's rsp_valid=0.
  - Next state is IDLE, or DRAIN if the drain flag is set.
  - Write responses also pulse rsp_valid; the rdata content is don't-care.
- DRAIN:
  - Ignore requests; hold req_ready=0.
  - Wait for the late mem_rsp_valid, discard it, clear the drain flag, go to IDLE.
  - DRAIN has no timeout.
- Latency: accept at cycle 0; mem_req_valid from cycle 1. If ready in cycle 1 and the response comes in cycle 2, the master sees rsp_valid in cycle 3.
- Back-to-back operation:
  - A new acceptance is possible in the cycle after RESP.
  - A requester held valid continuously alternates with the other requester under contention.
- Outputs are driven from registers and the state only, except req_ready. req_ready depends combinationally on req_valid, state and last_grant.

Decomposition:
- Package ysyx_24070016_mem_pkg holds:
  - the state enum (IDLE/REQ/WAIT/RESP/DRAIN);
  - master-ID constants (MID_IFU=0, MID_LSU=1).
- One sub-module: ysyx_24070016_rr_arb2, a 2-input round-robin arbiter.
  - Inputs: req[1:0], last_grant, enable.
  - Outputs: one-hot grant.
- The top-level FSM, holding registers and timeout counter stay in ysyx_24070016_mem_arbiter.

Test Plan:
- IFU alone: ifu_addr=0x80000000; memory ready at once and responds 1 cycle later with 0x00000413. Expect:
  - ifu_req_ready in cycle 0;
  - mem_addr=0x80000000 in cycle 1;
  - ifu_rsp_valid=1 with rdata=0x00000413, err=0 in cycle 3;
  - lsu_rsp_valid stays 0.
- Contention: both valid from reset, held for 4 transactions. Expect grant order IFU, LSU, IFU, LSU, with exactly one rsp pulse per grant routed to the correct master.
- LSU write: addr=0x80001000, wdata=0xDEADBEEF, wmask=0b0011; memory stalls mem_req_ready for 3 cycles. Expect:
  - mem_req_valid held for 4 cycles with the fields stable;
  - lsu_rsp_valid pulses exactly once.
- Timeout: TIMEOUT=4; memory accepts but never responds. Expect:
  - rsp_valid with err=1, rdata=0 when the counter reaches 4;
  - req_ready=0 while in DRAIN;
  - a late mem_rsp_valid is discarded, with no second rsp pulse;
  - the next request is accepted afterwards.
- Error pass-through: mem_rsp_err=1 on an IFU read gives ifu_rsp_err=1.
- Reset mid-op: assert rst low during WAIT. Expect all outputs 0 asynchronously and state IDLE; after release, IFU wins the first tie.
